// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // On a tie, the side that was not granted most recently wins.
  function automatic arb_state_t tie_winner(input logic last_side);
    return (last_side == SEL_A) ? GNT_B : GNT_A;
  endfunction

endpackage

// File: rtl/Mux2_1.sv
// Single-bit 2-to-1 multiplexer: F = a when sel = 0, b when sel = 1.
module Mux2_1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic F
);

  assign F = sel ? b : a;

endmodule

// File: rtl/hold_counter.sv
// Counts consecutive cycles a grant has been held; wraps at MAX_HOLD-1 and
// flags the last cycle of a hold window via terminal.
module hold_counter #(
  parameter int MAX_HOLD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] LAST_CNT = HW'(MAX_HOLD - 1);

  logic [HW-1:0] count;

  assign terminal = (count == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + HW'(1);
    end
  end

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter sharing one W-bit 2-to-1 mux between requesters A and B,
// with a forced handover after MAX_HOLD (>= 2) cycles of contention.
//
//   state | meaning
//   IDLE  | no grant; sel parks at its last value
//   GNT_A | A owns the output, sel = 0
//   GNT_B | B owns the output, sel = 1
module mux2_arbiter
  import mux_arb_pkg::*;
#(
  parameter int W        = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_a,
  input  logic         req_b,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gnt_a,
  output logic         gnt_b,
  output logic         sel,
  output logic [W-1:0] F,
  output logic         valid,
  output logic         preempt
);

  arb_state_t state, state_next;
  logic       last, last_next;
  logic       gnt_a_next, gnt_b_next, sel_next, preempt_next;
  logic       hold_term, hold_clear, hold_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= SEL_B;
      gnt_a   <= 1'b0;
      gnt_b   <= 1'b0;
      sel     <= SEL_A;
      preempt <= 1'b0;
    end else begin
      state   <= state_next;
      last    <= last_next;
      gnt_a   <= gnt_a_next;
      gnt_b   <= gnt_b_next;
      sel     <= sel_next;
      preempt <= preempt_next;
    end
  end

  always_comb begin
    state_next   = state;
    preempt_next = 1'b0;
    case (state)
      IDLE: begin
        if (req_a && req_b) state_next = tie_winner(last);
        else if (req_a)     state_next = GNT_A;
        else if (req_b)     state_next = GNT_B;
      end
      GNT_A: begin
        if (!req_a) begin
          state_next = req_b ? GNT_B : IDLE;
        end else if (req_b && hold_term) begin
          state_next   = GNT_B;
          preempt_next = 1'b1;
        end
      end
      GNT_B: begin
        if (!req_b) begin
          state_next = req_a ? GNT_A : IDLE;
        end else if (req_a && hold_term) begin
          state_next   = GNT_A;
          preempt_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt_a_next = (state_next == GNT_A);
    gnt_b_next = (state_next == GNT_B);
    sel_next   = sel;
    last_next  = last;
    if (state_next == GNT_A) begin
      sel_next  = SEL_A;
      last_next = SEL_A;
    end else if (state_next == GNT_B) begin
      sel_next  = SEL_B;
      last_next = SEL_B;
    end
    // Entry to a grant restarts the hold window; staying in it advances it.
    hold_clear = (state_next != IDLE) && (state_next != state);
    hold_en    = (state_next != IDLE) && (state_next == state);
  end

  hold_counter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (hold_clear),
    .enable   (hold_en),
    .terminal (hold_term)
  );

  assign valid = gnt_a | gnt_b;

  for (genvar i = 0; i < W; i++) begin : g_bit
    Mux2_1 u_mux (
      .a   (a[i]),
      .b   (b[i]),
      .sel (sel),
      .F   (F[i])
    );
  end

endmodule

// File: doc/mux2_arbiter.md
# mux2_arbiter

Round-robin arbiter that shares one 2-to-1 multiplexer datapath between two requesters, A and B. It grants the shared output to one requester at a time, drives the datapath `sel` from the grant, and forces a handover after a bounded number of cycles when both requesters contend. It sits between the two requesting blocks and the per-bit `Mux2_1` datapath. In the design it replaces a hand-driven `sel` input.

## Interface
Parameters:
- `W`, default 1: data width of each requester path and of `F`.
- `MAX_HOLD`, default 4: maximum consecutive granted cycles while the other side is requesting. Must be ≥ 2.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `req_a`  input  1  requester A wants the output.
- `req_b`  input  1  requester B wants the output.
- `a`  input  W  requester A data.
- `b`  input  W  requester B data.
- `gnt_a`  output  1  A owns the output; registered.
- `gnt_b`  output  1  B owns the output; registered.
- `sel`  output  1  datapath select, 0 = A and 1 = B; registered.
- `F`  output  W  muxed data, `a` when `sel`=0 and `b` when `sel`=1; combinational from `sel`.
- `valid`  output  1  equals `gnt_a | gnt_b`.
- `preempt`  output  1  one-cycle pulse in the first cycle of a grant caused by a forced handover.

## Operation
- States: IDLE, GNT_A, GNT_B.
- Internal `last` records the most recently granted side.
- Internal `hold` counter has width `$clog2(MAX_HOLD)`.
- Reset values:
  - state = IDLE, `last` = B (so A wins the first tie), `hold` = 0.
  - `gnt_a` = `gnt_b` = 0, `sel` = 0, `preempt` = 0.
  - `F` = `a`.
- IDLE transitions:
  - Only `req_a` high → GNT_A.
  - Only `req_b` high → GNT_B.
  - Both high → the side that is not `last`.
  - Neither → stay in IDLE.
- GNT_A (GNT_B is symmetric):
  - `req_a` low and `req_b` high → GNT_B.
  - `req_a` low and `req_b` low → IDLE.
  - `req_a` high, `req_b` high, `hold` = `MAX_HOLD-1` → GNT_B with `preempt` = 1.
  - `req_a` high, `req_b` high, `hold` = `MAX_HOLD-1` is the only forced-handover condition.
  - Otherwise → stay in GNT_A.
- Hold counter:
  - Cleared to 0 on entry to any grant state.
  - Increments each cycle the current grant is held.
  - When the other side is idle, wraps from `MAX_HOLD-1` to 0 and the grant is kept.
- `last` updates on every entry to GNT_A or GNT_B.
- `sel` follows the grant state. In IDLE it keeps its previous value (parks), so `F` stays stable.
- `gnt_a` and `gnt_b` are never high together. Handover A→B is direct, with no idle gap cycle.
- Requesters must hold `req` high until they see `gnt`. Dropping `req` before grant is legal; the grant may still arrive for one cycle.
- Reset asserted mid-grant drops both grants immediately, asynchronously. After release the block restarts from IDLE with `last` = B.

## Timing
- Grant latency: `req` sampled high at edge N → `gnt` and `sel` valid after edge N+1.
- Release latency: `req` sampled low at edge N → `gnt` low after edge N+1. A waiting side is granted at that same edge.
- Under continuous contention, each side holds for exactly `MAX_HOLD` cycles, then alternates.
- `F` settles combinationally within the cycle in which `sel` changes.
- `preempt` is high only for the first cycle of the forced grant.

## Structure
- Shared package `mux_arb_pkg`:
  - state enum `arb_state_t` {IDLE, GNT_A, GNT_B};
  - constants `SEL_A` = 0 and `SEL_B` = 1.
- Sub-module `hold_counter`: parameterised `MAX_HOLD`, with clear, enable, a `terminal` flag and wrap behaviour.
- The datapath is W instances of the existing `Mux2_1`, each driven by the registered `sel`.

## Test plan
- Reset: `rst_n`=0 with `req_a`=`req_b`=1 → `gnt_a`=`gnt_b`=0, `sel`=0. Release → `gnt_a`=1 after one edge (tie goes to A).
- Single requester: `req_b`=1 for 10 cycles, `req_a`=0 → `gnt_b` asserted 1 cycle after `req_b`, held all 10 cycles, no preempt. With `b`=1, `a`=0, `F`=1.
- Contention, `MAX_HOLD`=4, both requests held high: grant pattern A,A,A,A,B,B,B,B,A…, with `preempt`=1 on each switch cycle.
- Clean handover: A granted, `req_b`=1, then `req_a` drops at edge N → `gnt_a`=0 and `gnt_b`=1 after edge N+1, `preempt`=0.
- Park: both requests drop after a B grant → IDLE, `valid`=0, `sel` stays 1 and `F` tracks `b`.
- Async reset during GNT_B: `rst_n` low mid-cycle → `gnt_b` falls without waiting for a clock edge. After release with both requests high, A is granted first.
